// File: rtl/counter_pkg.sv
// Shared constants for the divide/prescale chain counters.
package counter_pkg;
  localparam int   WIDTH_DEF   = 4;
  localparam int   MOD_RST_DEF = 10;
  localparam logic UP          = 1'b1;
  localparam logic DOWN        = 1'b0;
endpackage

// File: rtl/mod_n_tick_counter_rise_detect.sv
// Rising-edge detector: one cycle pulse on a 0->1 of d, gated by en.
// The history flop tracks d even while disabled, so edges seen with en low are consumed.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic pulse
);
  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q & en;
endmodule

// File: rtl/mod_n_tick_counter.sv
// Modulo-N up/down event counter fed by the mod-2 toggle stage.
// Programmable modulus held in a shadow register, terminal-count pulse and sticky wrap flag.
module mod_n_tick_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MOD_RST = MOD_RST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             wrap_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);
  logic             evt, wrap_evt;
  logic [WIDTH-1:0] mod_q, mod_eff, top;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (tick_in),
    .pulse (evt)
  );

  // A zero modulus is treated as N=1 so top never underflows.
  assign mod_eff  = (mod_val == '0) ? WIDTH'(1) : mod_val;
  assign top      = mod_q - WIDTH'(1);
  assign wrap_evt = evt & ~load & ((up_dn == UP) ? (count == top) : (count == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      wrap  <= 1'b0;
      mod_q <= WIDTH'(MOD_RST);
    end else begin
      tc   <= wrap_evt;
      wrap <= wrap_evt | (wrap & ~wrap_clr);
      if (load) begin
        count <= (load_val >= mod_eff) ? '0 : load_val;
        mod_q <= mod_eff;
      end else if (evt) begin
        if (up_dn == UP) count <= wrap_evt ? '0  : count + WIDTH'(1);
        else             count <= wrap_evt ? top : count - WIDTH'(1);
      end
    end
  end
endmodule
